// File: rtl/operand_entry.sv
// Operand/opcode entry stage: debounces four push-buttons into single-cycle events,
// shifts switch chunks into operands A/B, and latches the opcode with a start strobe.
module operand_entry #(
  parameter int WIDTH     = 32,
  parameter int CHUNK     = 2,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_A,
  input  logic             btn_B,
  input  logic             btn_F,
  input  logic             btn_clr,
  input  logic [CHUNK-1:0] in,
  input  logic [3:0]       OP,
  output logic [WIDTH-1:0] opa,
  output logic [WIDTH-1:0] opb,
  output logic [3:0]       op_code,
  output logic             start,
  output logic [4:0]       a_cnt,
  output logic [4:0]       b_cnt,
  output logic             a_full,
  output logic             b_full
);

  localparam int             NCHUNK  = WIDTH / CHUNK;
  localparam int             DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [4:0]     FULL    = 5'(NCHUNK);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btn_clr, btn_F, btn_B, btn_A};

  // One debouncer per button; only the settled rising edge yields an event.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_db
      logic [1:0]     sync_q;
      logic [DBW-1:0] cnt_q, cnt_d;
      logic           stable_q, stable_d;
      logic           stable_dly_q;
      logic           press_q;

      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
          if (cnt_q == DB_LAST) begin
            stable_d = sync_q[1];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q       <= '0;
          cnt_q        <= '0;
          stable_q     <= 1'b0;
          stable_dly_q <= 1'b0;
          press_q      <= 1'b0;
        end else begin
          sync_q       <= {sync_q[0], btn_raw[gi]};
          cnt_q        <= cnt_d;
          stable_q     <= stable_d;
          stable_dly_q <= stable_q;
          press_q      <= stable_q & ~stable_dly_q;
        end
      end

      assign press[gi] = press_q;
    end
  endgenerate

  logic             clr_evt, a_evt, b_evt, f_evt;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [4:0]       a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [3:0]       op_code_q, op_code_d;
  logic             start_q, start_d;

  // Clear wins over any coincident event.
  assign clr_evt = press[3];
  assign a_evt   = press[0] & ~clr_evt;
  assign b_evt   = press[1] & ~clr_evt;
  assign f_evt   = press[2] & ~clr_evt;

  always_comb begin
    opa_d     = opa_q;
    opb_d     = opb_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    op_code_d = op_code_q;
    start_d   = f_evt;
    if (clr_evt) begin
      opa_d     = '0;
      opb_d     = '0;
      a_cnt_d   = '0;
      b_cnt_d   = '0;
      op_code_d = '0;
    end else begin
      if (a_evt) begin
        opa_d   = {opa_q[WIDTH-CHUNK-1:0], in};
        a_cnt_d = (a_cnt_q == FULL) ? FULL : a_cnt_q + 5'd1;
      end
      if (b_evt) begin
        opb_d   = {opb_q[WIDTH-CHUNK-1:0], in};
        b_cnt_d = (b_cnt_q == FULL) ? FULL : b_cnt_q + 5'd1;
      end
      if (f_evt) begin
        op_code_d = OP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q     <= '0;
      opb_q     <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      op_code_q <= '0;
      start_q   <= 1'b0;
    end else begin
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      op_code_q <= op_code_d;
      start_q   <= start_d;
    end
  end

  assign opa     = opa_q;
  assign opb     = opb_q;
  assign a_cnt   = a_cnt_q;
  assign b_cnt   = b_cnt_q;
  assign op_code = op_code_q;
  assign start   = start_q;
  assign a_full  = (a_cnt_q == FULL);
  assign b_full  = (b_cnt_q == FULL);

endmodule

// File: tb/tb_operand_entry.sv
// Randomized scoreboard bench for operand_entry: a press-level model predicts the
// output snapshot at each event edge; a negedge monitor checks every cycle.
module tb_operand_entry;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btns = 4'd0;
  logic [1:0]  sw_in = 2'd0;
  logic [3:0]  sw_op = 4'd0;
  logic [31:0] opa, opb;
  logic [3:0]  op_code;
  logic        start;
  logic [4:0]  a_cnt, b_cnt;
  logic        a_full, b_full;

  operand_entry #(.WIDTH(32), .CHUNK(2), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst),
    .btn_A(btns[0]), .btn_B(btns[1]), .btn_F(btns[2]), .btn_clr(btns[3]),
    .in(sw_in), .OP(sw_op),
    .opa(opa), .opb(opb), .op_code(op_code), .start(start),
    .a_cnt(a_cnt), .b_cnt(b_cnt), .a_full(a_full), .b_full(b_full)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  ac;
    logic [4:0]  bc;
    logic [3:0]  opc;
    logic        st;
  } snap_t;

  snap_t exp_q[$];
  snap_t cur_exp = '0;
  int    n_cmp = 0;
  int    n_err = 0;

  longint     m_opa = 0, m_opb = 0;
  int         m_ac = 0, m_bc = 0;
  logic [3:0] m_opc = 4'd0;

  // Press-level reference: apply one debounced event (mask = CLR,F,B,A) and
  // schedule the resulting snapshot for the edge it should appear on.
  function automatic void model_event(logic [3:0] mask, int unsigned at);
    snap_t s;
    if (mask[3]) begin
      m_opa = 0; m_opb = 0; m_ac = 0; m_bc = 0; m_opc = 4'd0;
    end else begin
      if (mask[0]) begin
        m_opa = (m_opa * 4 + longint'(sw_in)) % (64'd1 << 32);
        m_ac  = (m_ac >= 16) ? 16 : m_ac + 1;
      end
      if (mask[1]) begin
        m_opb = (m_opb * 4 + longint'(sw_in)) % (64'd1 << 32);
        m_bc  = (m_bc >= 16) ? 16 : m_bc + 1;
      end
      if (mask[2]) m_opc = sw_op;
    end
    s.cyc = at;
    s.opa = m_opa[31:0];
    s.opb = m_opb[31:0];
    s.ac  = 5'(m_ac);
    s.bc  = 5'(m_bc);
    s.opc = m_opc;
    s.st  = mask[2] & ~mask[3];
    exp_q.push_back(s);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      cur_exp = '0;
    end else begin
      cur_exp.st = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) cur_exp = exp_q.pop_front();
    end
    n_cmp++;
    if ({opa, opb, a_cnt, b_cnt, op_code, start, a_full, b_full} !==
        {cur_exp.opa, cur_exp.opb, cur_exp.ac, cur_exp.bc, cur_exp.opc, cur_exp.st,
         (cur_exp.ac == 5'd16), (cur_exp.bc == 5'd16)}) begin
      n_err++;
      $display("FAIL outputs cyc=%0d act opa=%h opb=%h ac=%0d bc=%0d opc=%h st=%b af=%b bf=%b exp opa=%h opb=%h ac=%0d bc=%0d opc=%h st=%b",
               cyc, opa, opb, a_cnt, b_cnt, op_code, start, a_full, b_full,
               cur_exp.opa, cur_exp.opb, cur_exp.ac, cur_exp.bc, cur_exp.opc, cur_exp.st);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic press(logic [3:0] mask);
    int h, g;
    h = $urandom_range(DB + 4, DB + 10);
    g = $urandom_range(DB + 3, DB + 8);
    btns = mask;
    model_event(mask, cyc + DB + 4);
    $display("press mask=%b in=%b op=%h hold=%0d", mask, sw_in, sw_op, h);
    tick(h);
    btns = 4'd0;
    tick(g);
  endtask

  initial begin
    int unsigned r;
    logic [3:0]  mask;

    tick(3);
    rst = 1'b0;
    chk("reset_opa", opa, 32'd0);
    chk("reset_opb", opb, 32'd0);
    chk("reset_cnts", {22'd0, a_cnt, b_cnt}, 32'd0);
    chk("reset_opcode_start", {27'd0, op_code, start}, 32'd0);
    tick(100);

    // Glitch shorter than the debounce window
    btns = 4'b0001;
    tick(3);
    btns = 4'd0;
    tick(DB + 8);
    chk("glitch_a_cnt", 32'(a_cnt), 32'd0);
    chk("glitch_opa", opa, 32'd0);

    sw_in = 2'b10;
    repeat (16) press(4'b0001);
    chk("fill_opa", opa, 32'hAAAA_AAAA);
    chk("fill_a_cnt", 32'(a_cnt), 32'd16);
    chk("fill_a_full", 32'(a_full), 32'd1);
    sw_in = 2'b01;
    press(4'b0001);
    chk("past_full_opa", opa, 32'hAAAA_AAA9);
    chk("past_full_a_cnt", 32'(a_cnt), 32'd16);

    sw_in = 2'b11;
    press(4'b0010);
    press(4'b0010);
    sw_op = 4'h5;
    btns  = 4'b0100;
    r     = cyc;
    model_event(4'b0100, r + DB + 4);
    tick(DB + 3);
    chk("start_before", 32'(start), 32'd0);
    tick(1);
    chk("start_on", 32'(start), 32'd1);
    tick(1);
    chk("start_after", 32'(start), 32'd0);
    tick(4);
    btns = 4'd0;
    tick(DB + 6);
    chk("f_opb", opb, 32'h0000_000F);
    chk("f_op_code", 32'(op_code), 32'd5);

    press(4'b1001);
    chk("clr_opa", opa, 32'd0);
    chk("clr_a_cnt", 32'(a_cnt), 32'd0);
    chk("clr_opb", opb, 32'd0);

    repeat (40) begin
      sw_in = 2'($urandom);
      sw_op = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 2)      mask = 4'b0001;
      else if (r <= 5) mask = 4'b0010;
      else if (r <= 7) mask = 4'b0100;
      else if (r == 8) mask = 4'b0011;
      else             mask = {1'b1, 3'($urandom)};
      press(mask);
    end

    // Long hold yields exactly one start
    sw_op = 4'hC;
    btns  = 4'b0100;
    model_event(4'b0100, cyc + DB + 4);
    tick(50);
    btns = 4'd0;
    tick(DB + 8);

    // Reset in the middle of a held F press
    sw_op = 4'h9;
    btns  = 4'b0100;
    model_event(4'b0100, cyc + DB + 4);
    tick(20);
    rst = 1'b1;
    exp_q.delete();
    m_opa = 0; m_opb = 0; m_ac = 0; m_bc = 0; m_opc = 4'd0;
    tick(2);
    chk("rst_hold_opcode_start", {27'd0, op_code, start}, 32'd0);
    rst = 1'b0;
    model_event(4'b0100, cyc + DB + 4);
    tick(DB + 20);
    chk("post_rst_op_code", 32'(op_code), 32'h9);
    btns = 4'd0;
    tick(DB + 8);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
